ysyx_22041461_div_unit: RTL
===========================

// Module: ysyx_22041461_div_unit
// PURPOSE
//  Multi-cycle integer divider for the EX stage; runs beside the single-cycle ALU.
//  Takes the same src1/src2 operands from ID/EX.
//  Executes RV64M DIV/DIVU/REM/REMU and the W variants.
//  Its result joins the ALU result at the EX writeback mux.
//  Radix-2 restoring division, one quotient bit per cycle; EX stalls while busy.
// PARAMETERS
//  XLEN      64   operand/result width
//  CNT_W     7    iteration counter width; holds values 0..XLEN
// PORTS
//  clk        in   1     system clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  flush      in   1     pipeline flush; aborts any op in flight
//  in_valid   in   1     operands valid
//  in_ready   out  1     divider can accept (state IDLE)
//  src1       in   XLEN  dividend
//  src2       in   XLEN  divisor
//  div_signed in   1     1 = DIV/REM(W); 0 = DIVU/REMU(W)
//  div_rem    in   1     1 = return remainder; 0 = return quotient
//  div_word   in   1     1 = *W op on src[31:0]; result sign-extended to XLEN
//  out_valid  out  1     result valid; held until out_ready
//  out_ready  in   1     EX consumes result
//  div_out    out  XLEN  quotient or remainder
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, div_out=0, counter=0.
//  Accept: on in_valid&&in_ready. Latch op bits and absolute-value operands.
//    Word op: operand = sign- or zero-extension of bits [31:0] per div_signed.
//    Also latch sign_q = sA^sB and sign_r = sA (signed ops only).
//  FSM: IDLE -> CALC on accept (normal case).
//    IDLE -> DONE on accept for special cases; result set in the same edge.
//    CALC -> DONE when counter reaches N: N=64 (XLEN), N=32 for word ops.
//    DONE -> IDLE when out_valid&&out_ready.
//  CALC step: {rem,quo} <<= 1; if rem>=divisor then rem-=divisor and quo[0]=1;
//    counter++.
//  Final fix-up on entering DONE: negate quo if sign_q; negate rem if sign_r.
//    Word ops: take [31:0] and sign-extend to 64, for DIVU/REMU too (RISC-V rule).
//  Latency: accept at cycle t -> out_valid at t+N+1.
//    Special cases: out_valid at t+1.
//  Special cases (RISC-V spec):
//    divide by zero: quotient = all ones (word ops: 0xFFFF_FFFF sign-ext);
//      remainder = dividend (word ops: sign-ext [31:0]).
//    signed overflow MIN/-1: quotient = MIN; remainder = 0.
//      Word ops use MIN = 0x8000_0000, sign-extended.
//  out_valid and div_out stay stable until out_ready; no new accept until then.
//  flush has priority over everything except rst.
//    Any state -> IDLE next edge; out_valid=0; latched result discarded.
//    in_valid on a flush cycle is ignored.
//  in_ready is combinational from state only; it does not depend on in_valid.
//  rst during CALC: same effect as reset; no partial result becomes visible.
// STRUCTURE
//  Shared package (ysyx_22041461_pkg) holds:
//    XLEN; the div state encoding (IDLE/CALC/DONE); the div op-bit localparams
//    used by the decoder.
//  One sub-module: ysyx_22041461_div_step.
//    Combinational single iteration: shift, compare, subtract.
//    In {rem,quo,divisor}; out {rem,quo}.
//  FSM, counter, sign handling and special-case detection stay in the top.
// TESTING
//  1. DIVU 100/7, then REMU -> 14 then 2; out_valid exactly 65 cycles after accept.
//  2. DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 -> -1.
//     out_valid held 5 cycles while out_ready=0.
//  3. Divide by zero: DIV 5/0 -> all ones; REM 5/0 -> 5.
//     out_valid 1 cycle after accept.
//  4. DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000.
//     REMW 0x8000_0000/0xFFFF_FFFF -> 0.
//  5. DIVUW src1=0x1_FFFF_FFFE, src2=2 -> 0x7FFF_FFFF; latency 33 cycles.
//     DIVW 0xFFFF_FFF0/4 -> 0xFFFF_FFFF_FFFF_FFFC.
//  6. flush 10 cycles into CALC -> IDLE next cycle; in_ready=1; no out_valid.
//     A following DIVU 9/3 -> 3 with correct latency.
//     Repeat the abort with rst instead of flush.

Source files
------------

// File: rtl/ysyx_22041461_pkg.sv
// Shared definitions for the EX-stage divider: widths, FSM encoding,
// op-bit bundle and the RV64M divide op encodings used by the decoder.
package ysyx_22041461_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Op bits carried from decode: word (*W), rem (remainder), sgn (signed)
    typedef struct packed {
        logic word;
        logic rem;
        logic sgn;
    } div_op_t;

    localparam div_op_t DIV_OP_DIV   = '{word: 1'b0, rem: 1'b0, sgn: 1'b1};
    localparam div_op_t DIV_OP_DIVU  = '{word: 1'b0, rem: 1'b0, sgn: 1'b0};
    localparam div_op_t DIV_OP_REM   = '{word: 1'b0, rem: 1'b1, sgn: 1'b1};
    localparam div_op_t DIV_OP_REMU  = '{word: 1'b0, rem: 1'b1, sgn: 1'b0};
    localparam div_op_t DIV_OP_DIVW  = '{word: 1'b1, rem: 1'b0, sgn: 1'b1};
    localparam div_op_t DIV_OP_DIVUW = '{word: 1'b1, rem: 1'b0, sgn: 1'b0};
    localparam div_op_t DIV_OP_REMW  = '{word: 1'b1, rem: 1'b1, sgn: 1'b1};
    localparam div_op_t DIV_OP_REMUW = '{word: 1'b1, rem: 1'b1, sgn: 1'b0};

    // Sign-extend a 32-bit value to XLEN
    function automatic logic [XLEN-1:0] sext32(input logic [WORD_W-1:0] v);
        return {{(XLEN-WORD_W){v[WORD_W-1]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22041461_div_unit_if.sv
// Divider operand/result handshake bundle between EX control and the divider.
//   in_valid/in_ready  : operand handshake (src1, src2, div_signed/rem/word)
//   out_valid/out_ready: result handshake (div_out)
// master = EX side, slave = divider.
interface ysyx_22041461_div_unit_if;
    import ysyx_22041461_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            div_signed;
    logic            div_rem;
    logic            div_word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] div_out;

    modport master (
        output in_valid, src1, src2, div_signed, div_rem, div_word, out_ready,
        input  in_ready, out_valid, div_out
    );

    modport slave (
        input  in_valid, src1, src2, div_signed, div_rem, div_word, out_ready,
        output in_ready, out_valid, div_out
    );

endinterface

// File: rtl/ysyx_22041461_div_step.sv
// One radix-2 restoring division iteration (combinational).
//   i_rem, i_quo : partial remainder and dividend/quotient shift register
//   i_dvs        : divisor magnitude
//   o_rem, o_quo : values after shift, compare and conditional subtract
module ysyx_22041461_div_step
    import ysyx_22041461_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvs,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    // Shifted remainder needs one extra bit: 2*rem+1 can exceed XLEN bits
    logic [XLEN:0] w_rem_sh;
    logic          w_ge;

    assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, i_dvs});

    // When w_ge holds the difference is below the divisor, so XLEN bits suffice
    assign o_rem = w_ge ? (w_rem_sh[XLEN-1:0] - i_dvs) : w_rem_sh[XLEN-1:0];
    assign o_quo = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/ysyx_22041461_div_unit.sv
// Multi-cycle RV64M divider (DIV/DIVU/REM/REMU and *W), radix-2 restoring,
// one quotient bit per cycle.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   flush : aborts any op in flight, discards a pending result
//   bus   : slave side of the operand/result handshake bundle
module ysyx_22041461_div_unit
    import ysyx_22041461_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    ysyx_22041461_div_unit_if.slave     bus
);

    div_state_e      r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [XLEN-1:0] r_rem,     w_rem_nxt;
    logic [XLEN-1:0] r_quo,     w_quo_nxt;
    logic [XLEN-1:0] r_dvs,     w_dvs_nxt;
    div_op_t         r_op,      w_op_nxt;
    logic            r_sign_q,  w_sign_q_nxt;
    logic            r_sign_r,  w_sign_r_nxt;
    logic [XLEN-1:0] r_out,     w_out_nxt;
    logic            r_out_valid, w_out_valid_nxt;

    // Operand preparation
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_a_sx, w_min;
    logic [XLEN-1:0] w_quo_load, w_spec_res;
    logic            w_sa, w_sb, w_div_zero, w_ovf;

    // Iteration and fix-up
    logic [XLEN-1:0] w_step_rem, w_step_quo, w_q_fin, w_r_fin, w_res, w_res_fin;
    logic [CNT_W-1:0] w_last;

    // Extend, take magnitudes and spot the two special cases at accept time
    always_comb begin
        w_a_sx  = bus.div_word ? sext32(bus.src1[WORD_W-1:0]) : bus.src1;
        w_a_ext = bus.src1;
        w_b_ext = bus.src2;
        if (bus.div_word) begin
            w_a_ext = bus.div_signed ? sext32(bus.src1[WORD_W-1:0])
                                     : {{(XLEN-WORD_W){1'b0}}, bus.src1[WORD_W-1:0]};
            w_b_ext = bus.div_signed ? sext32(bus.src2[WORD_W-1:0])
                                     : {{(XLEN-WORD_W){1'b0}}, bus.src2[WORD_W-1:0]};
        end
        w_sa    = bus.div_signed & w_a_ext[XLEN-1];
        w_sb    = bus.div_signed & w_b_ext[XLEN-1];
        w_a_abs = w_sa ? -w_a_ext : w_a_ext;
        w_b_abs = w_sb ? -w_b_ext : w_b_ext;
        // Word ops run 32 iterations, so the dividend must start in the top half
        w_quo_load = bus.div_word ? (w_a_abs << (XLEN - WORD_W)) : w_a_abs;

        w_min = bus.div_word ? sext32({1'b1, {(WORD_W-1){1'b0}}})
                             : {1'b1, {(XLEN-1){1'b0}}};
        w_div_zero = (w_b_ext == '0);
        w_ovf      = bus.div_signed && (w_a_ext == w_min) && (w_b_ext == '1);

        if (w_div_zero) begin
            w_spec_res = bus.div_rem ? w_a_sx : '1;
        end else begin
            w_spec_res = bus.div_rem ? '0 : w_min;
        end
    end

    ysyx_22041461_div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // Sign fix-up applied to the final iteration's outputs
    always_comb begin
        w_last    = r_op.word ? CNT_W'(WORD_W - 1) : CNT_W'(XLEN - 1);
        w_q_fin   = r_sign_q ? -w_step_quo : w_step_quo;
        w_r_fin   = r_sign_r ? -w_step_rem : w_step_rem;
        w_res     = r_op.rem ? w_r_fin : w_q_fin;
        w_res_fin = r_op.word ? sext32(w_res[WORD_W-1:0]) : w_res;
    end

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= DIV_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_op        <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rem       <= w_rem_nxt;
            r_quo       <= w_quo_nxt;
            r_dvs       <= w_dvs_nxt;
            r_op        <= w_op_nxt;
            r_sign_q    <= w_sign_q_nxt;
            r_sign_r    <= w_sign_r_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rem_nxt       = r_rem;
        w_quo_nxt       = r_quo;
        w_dvs_nxt       = r_dvs;
        w_op_nxt        = r_op;
        w_sign_q_nxt    = r_sign_q;
        w_sign_r_nxt    = r_sign_r;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            DIV_IDLE: begin
                if (bus.in_valid) begin
                    w_op_nxt     = '{word: bus.div_word, rem: bus.div_rem, sgn: bus.div_signed};
                    w_sign_q_nxt = w_sa ^ w_sb;
                    w_sign_r_nxt = w_sa;
                    w_cnt_nxt    = '0;
                    if (w_div_zero || w_ovf) begin
                        w_state_nxt     = DIV_DONE;
                        w_out_nxt       = w_spec_res;
                        w_out_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DIV_CALC;
                        w_rem_nxt   = '0;
                        w_quo_nxt   = w_quo_load;
                        w_dvs_nxt   = w_b_abs;
                    end
                end
            end
            DIV_CALC: begin
                w_rem_nxt = w_step_rem;
                w_quo_nxt = w_step_quo;
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // Last iteration lands straight in DONE with the fixed-up result
                if (r_cnt == w_last) begin
                    w_state_nxt     = DIV_DONE;
                    w_out_nxt       = w_res_fin;
                    w_out_valid_nxt = 1'b1;
                end
            end
            DIV_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt     = DIV_IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = DIV_IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase

        // Flush overrides everything above, including an accept this cycle
        if (flush) begin
            w_state_nxt     = DIV_IDLE;
            w_cnt_nxt       = '0;
            w_out_nxt       = '0;
            w_out_valid_nxt = 1'b0;
        end
    end

    assign bus.in_ready  = (r_state == DIV_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.div_out   = r_out;

endmodule
